opb_register_simulink2ppc_status: RTL and testbench



---
 rtl/opb_reg_pkg.sv | 38 +++
 rtl/opb_slave_ack_fsm.sv | 62 ++++++
 rtl/opb_register_simulink2ppc_status.sv | 118 +++++++++++
 tb/tb_opb_register_simulink2ppc_status.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register slaves: register offsets, status bit
// positions, slave FSM states and OPB/user bit-numbering helpers.
package opb_reg_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam int unsigned STAT_NEW = 0;
  localparam int unsigned STAT_OVR = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } opb_state_e;

  // OPB bit i is user bit 31-i. Reversing the index while also reversing the
  // range direction leaves the numeric value unchanged.
  function automatic logic [0:31] to_opb(input logic [31:0] u);
    logic [0:31] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = u[31-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] to_user(input logic [0:31] o);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[31-i] = o[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and IDLE/ACK/WAIT handshake: one wait state, a
// single-cycle ack, and no re-ack while the master keeps select asserted.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E1FF,
  parameter int unsigned C_OPB_AWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:C_OPB_AWIDTH-1] opb_abus,
  input  logic                    opb_select,
  input  logic                    opb_rnw,
  output logic                    hit,
  output logic                    ack,
  output logic                    rd_en,
  output logic                    wr_en,
  output logic [1:0]              word_idx
);

  localparam logic [0:C_OPB_AWIDTH-1] BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [0:C_OPB_AWIDTH-1] HIGH = C_HIGHADDR[C_OPB_AWIDTH-1:0];

  opb_state_e state, state_next;
  logic [1:0] idx_q;
  logic       rnw_q;

  assign hit = opb_select && (opb_abus >= BASE) && (opb_abus <= HIGH);

  // Direction and word index are held from the hit so a select dropped
  // during ACK still completes the transfer that was decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx_q <= '0;
      rnw_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && hit) begin
        idx_q <= opb_abus[C_OPB_AWIDTH-4 +: 2];
        rnw_q <= opb_rnw;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = WAIT;
      WAIT:    if (!opb_select) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ack      = (state == ACK);
  assign rd_en    = ack && rnw_q;
  assign wr_en    = ack && !rnw_q;
  assign word_idx = idx_q;

endmodule

// File: rtl/opb_register_simulink2ppc_status.sv
// Fabric-to-software OPB register: captures a fabric word on user_valid and
// exposes it with a NEW/OVR status word and a capture counter.
module opb_register_simulink2ppc_status
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E1FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid
);

  logic        hit, ack, rd_en, wr_en;
  logic [1:0]  word_idx;
  logic [31:0] data_q, count_q;
  logic        new_q, ovr_q;
  logic        new_next, ovr_next;
  logic        data_rd, ovr_w1c;
  logic [31:0] status_word, rd_word;
  logic        unused;

  opb_slave_ack_fsm #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH)
  ) u_fsm (
    .clk       (OPB_Clk),
    .rst_n     (OPB_Rst_n),
    .opb_abus  (OPB_ABus),
    .opb_select(OPB_select),
    .opb_rnw   (OPB_RNW),
    .hit       (hit),
    .ack       (ack),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .word_idx  (word_idx)
  );

  assign data_rd = rd_en && (word_idx == OFS_DATA);
  assign ovr_w1c = wr_en && (word_idx == OFS_STATUS)
                   && OPB_BE[C_OPB_DWIDTH/8-1]
                   && OPB_DBus[C_OPB_DWIDTH-1-STAT_OVR];

  // A capture coinciding with the DATA read keeps NEW set and is not an
  // overrun; an overrun set takes priority over a same-cycle W1C.
  always_comb begin
    new_next = new_q;
    ovr_next = ovr_q;
    if (user_valid) begin
      new_next = 1'b1;
    end else if (data_rd) begin
      new_next = 1'b0;
    end
    if (ovr_w1c) begin
      ovr_next = 1'b0;
    end
    if (user_valid && new_q && !data_rd) begin
      ovr_next = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      new_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (user_valid) begin
        data_q  <= user_data_in;
        count_q <= count_q + 32'd1;
      end
      new_q <= new_next;
      ovr_q <= ovr_next;
    end
  end

  always_comb begin
    status_word           = '0;
    status_word[STAT_NEW] = new_q;
    status_word[STAT_OVR] = ovr_q;
  end

  always_comb begin
    rd_word = '0;
    case (word_idx)
      OFS_DATA:   rd_word = data_q;
      OFS_STATUS: rd_word = status_word;
      OFS_COUNT:  rd_word = count_q;
      default:    rd_word = '0;
    endcase
  end

  assign Sl_DBus    = rd_en ? to_opb(rd_word) : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused = ^{OPB_seqAddr, OPB_BE, OPB_DBus, hit, (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_status.sv
// Directed bench for opb_register_simulink2ppc_status.
module tb_opb_register_simulink2ppc_status;

  logic        OPB_Clk;
  logic        OPB_Rst_n;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic [31:0] user_data_in;
  logic        user_valid;

  int errors = 0;
  int checks = 0;
  int viol = 0;
  int ack_cnt = 0;

  localparam logic [31:0] A_DATA   = 32'h0100E100;
  localparam logic [31:0] A_STATUS = 32'h0100E104;
  localparam logic [31:0] A_COUNT  = 32'h0100E108;
  localparam logic [31:0] A_RSVD   = 32'h0100E10C;
  localparam logic [31:0] A_MISS   = 32'h0100E200;

  opb_register_simulink2ppc_status #(
    .C_BASEADDR  (32'h0100E100),
    .C_HIGHADDR  (32'h0100E1FF),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex6")
  ) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst_n   (OPB_Rst_n),
    .Sl_DBus     (Sl_DBus),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .Sl_xferAck  (Sl_xferAck),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .user_data_in(user_data_in),
    .user_valid  (user_valid)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  always @(negedge OPB_Clk) begin
    if (Sl_errAck || Sl_retry || Sl_toutSup) viol++;
    if (!Sl_xferAck && Sl_DBus != '0) viol++;
    if (Sl_xferAck) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transfer; optional capture pulse aligned to the ack edge.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic cap, input logic [31:0] cd,
                      output logic [31:0] rd, output int lat);
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = addr; OPB_BE = be; OPB_DBus = wd;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) begin
        lat = n;
        rd  = Sl_DBus;
        if (cap) begin
          user_valid = 1'b1; user_data_in = cd;
        end
        break;
      end
    end
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    user_valid = 1'b0;
  endtask

  task automatic capture(input logic [31:0] d);
    @(posedge OPB_Clk); #1;
    user_valid = 1'b1; user_data_in = d;
    @(posedge OPB_Clk); #1;
    user_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int ack0;

    OPB_Rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    OPB_RNW = 1'b0; OPB_select = 1'b0; OPB_seqAddr = 1'b0;
    user_data_in = '0; user_valid = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    chk("rst_dbus", Sl_DBus, 32'd0);
    OPB_Rst_n = 1'b1;

    xfer(1'b1, A_DATA, 4'hF, '0, 1'b0, '0, rd, lat);
    chk("rst_data", rd, 32'h0); chk("lat_data", lat, 2);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat);
    chk("rst_status", rd, 32'h0); chk("lat_status", lat, 2);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);
    chk("rst_count", rd, 32'h0); chk("lat_count", lat, 2);

    capture(32'hDEADBEEF);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("status_new", rd, 32'h1);
    xfer(1'b1, A_DATA, 4'hF, '0, 1'b0, '0, rd, lat);   chk("data_deadbeef", rd, 32'hDEADBEEF);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("status_cleared", rd, 32'h0);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_1", rd, 32'd1);

    capture(32'h1); capture(32'h2); capture(32'h3);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("status_ovr", rd, 32'h3);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_4", rd, 32'd4);

    xfer(1'b0, A_STATUS, 4'b0001, 32'h2, 1'b0, '0, rd, lat);
    chk("lat_write", lat, 2);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("w1c_be3", rd, 32'h1);
    capture(32'h4);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("ovr_again", rd, 32'h3);
    xfer(1'b0, A_STATUS, 4'b1110, 32'h2, 1'b0, '0, rd, lat);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("w1c_no_be3", rd, 32'h3);
    xfer(1'b0, A_DATA, 4'hF, 32'hFFFFFFFF, 1'b0, '0, rd, lat);
    xfer(1'b0, A_COUNT, 4'hF, 32'h0, 1'b0, '0, rd, lat);
    xfer(1'b0, A_STATUS, 4'hF, 32'h1, 1'b0, '0, rd, lat);
    xfer(1'b1, A_DATA, 4'hF, '0, 1'b0, '0, rd, lat);   chk("data_ro", rd, 32'h4);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_ro", rd, 32'd5);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("status_ovr_only", rd, 32'h2);
    xfer(1'b0, A_STATUS, 4'hF, 32'h2, 1'b0, '0, rd, lat);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("status_zero", rd, 32'h0);

    capture(32'h12345678);
    xfer(1'b0, A_STATUS, 4'hF, 32'h2, 1'b1, 32'h0BADC0DE, rd, lat);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("set_wins", rd, 32'h3);
    xfer(1'b0, A_STATUS, 4'hF, 32'h2, 1'b0, '0, rd, lat);
    xfer(1'b1, A_DATA, 4'hF, '0, 1'b1, 32'hCAFEF00D, rd, lat);
    chk("rd_old_word", rd, 32'h0BADC0DE);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("cap_on_rd_status", rd, 32'h1);
    xfer(1'b1, A_DATA, 4'hF, '0, 1'b0, '0, rd, lat);   chk("rd_new_word", rd, 32'hCAFEF00D);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_8", rd, 32'd8);

    ack0 = ack_cnt;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = A_COUNT; OPB_BE = 4'hF;
    repeat (6) @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
    repeat (2) @(posedge OPB_Clk);
    chk("held_select_acks", ack_cnt - ack0, 32'd1);
    xfer(1'b1, A_RSVD, 4'hF, '0, 1'b0, '0, rd, lat);   chk("rsvd_zero", rd, 32'h0);

    ack0 = ack_cnt;
    xfer(1'b1, A_MISS, 4'hF, '0, 1'b0, '0, rd, lat);
    chk("miss_no_ack", lat, 0);
    chk("miss_ack_cnt", ack_cnt - ack0, 32'd0);

    @(negedge OPB_Clk);
    force dut.count_q = 32'hFFFFFFFF;
    @(negedge OPB_Clk);
    release dut.count_q;
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_max", rd, 32'hFFFFFFFF);
    capture(32'h5A5A5A5A);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("count_wrap", rd, 32'h0);

    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = A_DATA; OPB_BE = 4'hF;
    @(negedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("pre_rst_ack", {31'd0, Sl_xferAck}, 32'd1);
    OPB_Rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    chk("mid_rst_dbus", Sl_DBus, 32'h0);
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
    repeat (2) @(posedge OPB_Clk);
    #1;
    OPB_Rst_n = 1'b1;
    xfer(1'b1, A_DATA, 4'hF, '0, 1'b0, '0, rd, lat);
    chk("post_rst_data", rd, 32'h0); chk("post_rst_lat", lat, 2);
    xfer(1'b1, A_STATUS, 4'hF, '0, 1'b0, '0, rd, lat); chk("post_rst_status", rd, 32'h0);
    xfer(1'b1, A_COUNT, 4'hF, '0, 1'b0, '0, rd, lat);  chk("post_rst_count", rd, 32'h0);

    repeat (2) @(posedge OPB_Clk);
    chk("bus_signal_violations", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
